// File: rtl/lift_pkg.sv
// lift_pkg: shared state encoding, defaults and length check for the lifting line buffer
package lift_pkg;
  localparam int LIFT_DATA_W = 26;
  localparam int LIFT_ADDR_W = 7;
  localparam int unsigned MIN_LEN = 4;
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_RD0, S_RD1, S_OUT, S_FIN} state_t;
  function automatic logic len_ok(input int unsigned n, input int unsigned max_n);
    return !n[0] && n >= MIN_LEN && n <= max_n;
  endfunction
endpackage

// File: rtl/lift_bank_ram.sv
// lift_bank_ram: single-port RAM, sync read with a read register that holds between reads
module lift_bank_ram #(
  parameter int W  = 26,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem_q [2**AW];
  logic [W-1:0] rdata_q;
  always_ff @(posedge clk) begin
    if (en && we) mem_q[addr] <= wdata;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) rdata_q <= '0;
    else if (en && !we) rdata_q <= mem_q[addr];
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/lift_line_buf.sv
// lift_line_buf: even/odd line buffer streaming (left, odd, right) tuples with symmetric row-end extension
module lift_line_buf
  import lift_pkg::*;
#(
  parameter int DATA_W = LIFT_DATA_W,
  parameter int ADDR_W = LIFT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   cfg_len,
  output logic              cfg_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] pix_dout_l,
  output logic [DATA_W-1:0] pix_dout_odd,
  output logic [DATA_W-1:0] pix_dout_r,
  output logic              done,
  output logic              busy
);
  localparam int BW = ADDR_W - 1;
  state_t state_q, state_d;
  logic [ADDR_W:0] len_q, len_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic [BW-1:0] k_q, k_d;
  logic [DATA_W-1:0] l_q, l_d, odd_q, odd_d, ev_rd, od_rd;
  logic cfg_err_q, cfg_err_d;
  logic start_ok, beat, fill_last, row_last, ev_en, od_en;
  logic [BW-1:0] ev_addr, od_addr;
  assign start_ok  = len_ok(32'(cfg_len), 2**ADDR_W);
  assign beat      = state_q == S_FILL && in_valid;
  assign fill_last = {1'b0, i_q} + 1'b1 == len_q;
  assign row_last  = {1'b0, k_q, 1'b1} + 1'b1 == len_q;
  // At the row end the even read register is left holding even[k], which is the mirrored x[N-2]
  assign ev_en   = (beat && !i_q[0]) || state_q == S_RD0 || (state_q == S_RD1 && !row_last);
  assign od_en   = (beat && i_q[0]) || state_q == S_RD0;
  assign ev_addr = state_q == S_FILL ? i_q[ADDR_W-1:1] : state_q == S_RD1 ? k_q + 1'b1 : k_q;
  assign od_addr = state_q == S_FILL ? i_q[ADDR_W-1:1] : k_q;
  lift_bank_ram #(.W(DATA_W), .AW(BW)) u_even (
    .clk(clk), .rst_n(rst_n), .en(ev_en), .we(state_q == S_FILL),
    .addr(ev_addr), .wdata(in_data), .rdata(ev_rd)
  );
  lift_bank_ram #(.W(DATA_W), .AW(BW)) u_odd (
    .clk(clk), .rst_n(rst_n), .en(od_en), .we(state_q == S_FILL),
    .addr(od_addr), .wdata(in_data), .rdata(od_rd)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      i_q       <= '0;
      k_q       <= '0;
      l_q       <= '0;
      odd_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      i_q       <= i_d;
      k_q       <= k_d;
      l_q       <= l_d;
      odd_q     <= odd_d;
      cfg_err_q <= cfg_err_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    i_d       = i_q;
    k_d       = k_q;
    l_d       = l_q;
    odd_d     = odd_q;
    cfg_err_d = state_q == S_IDLE && start && !start_ok;
    case (state_q)
      S_IDLE: if (start && start_ok) begin
        state_d = S_FILL;
        len_d   = cfg_len;
        i_d     = '0;
        k_d     = '0;
      end
      S_FILL: if (in_valid) begin
        i_d     = i_q + 1'b1;
        state_d = fill_last ? S_RD0 : S_FILL;
      end
      S_RD0: state_d = S_RD1;
      S_RD1: begin
        l_d     = ev_rd;
        odd_d   = od_rd;
        state_d = S_OUT;
      end
      S_OUT: if (out_ready) begin
        state_d = row_last ? S_FIN : S_RD0;
        k_d     = row_last ? k_q : k_q + 1'b1;
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  assign cfg_err      = cfg_err_q;
  assign in_ready     = state_q == S_FILL;
  assign out_valid    = state_q == S_OUT;
  assign done         = state_q == S_FIN;
  assign busy         = state_q != S_IDLE;
  assign pix_dout_l   = l_q;
  assign pix_dout_odd = odd_q;
  assign pix_dout_r   = ev_rd;
endmodule

// File: doc/lift_line_buf.md
# lift_line_buf

Parametrised line buffer for the 5/3 lifting datapath. It accepts one image row of pixels in raster order and splits it into even and odd sample banks. It then streams (left, odd, right) tuples to the predict stage, applying symmetric boundary extension at the end of the row. It supersedes the fixed 26-bit × 128 even/odd/left/right RAM arrangement with a configurable width, depth and line length, plus valid/ready flow control.

## Interface
Parameters:
- DATA_W, 26, pixel/coefficient width in bits
- ADDR_W, 7, log2 of maximum line length; max line length is 2^ADDR_W samples

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; begins a new line (honoured in IDLE only)
- cfg_len  in  ADDR_W+1  line length N, sampled on start
- cfg_err  out  1  registered; high for one cycle when start carries an illegal N
- in_valid  in  1  input sample valid
- in_ready  out  1  high only in FILL
- in_data  in  DATA_W  pixel, raster order x[0]..x[N-1]
- out_valid  out  1  tuple valid
- out_ready  in  1  downstream accepts tuple
- pix_dout_l  out  DATA_W  left even sample x[2k]
- pix_dout_odd  out  DATA_W  odd sample x[2k+1]
- pix_dout_r  out  DATA_W  right even sample x[2k+2], mirrored at the row end
- done  out  1  one-cycle pulse after the last tuple is accepted
- busy  out  1  high in every state except IDLE

## Operation
- Storage: two banks, even and odd, each 2^(ADDR_W-1) words × DATA_W, with synchronous read and one-cycle latency.
- Legal N: even, 4 ≤ N ≤ 2^ADDR_W.
  - Start with an illegal N: cfg_err pulses, the FSM stays in IDLE, and cfg_len is not latched.
- FSM states: IDLE, FILL, RD0, RD1, OUT, FIN.
- IDLE → FILL on start with a legal N. Latch N and clear the write index i and the tuple index k.
- FILL: each in_valid && in_ready beat writes x[i].
  - Even i goes to even[i>>1]; odd i goes to odd[i>>1]. Then i increments.
  - The beat with i = N-1 moves the FSM to RD0.
- RD0: issue reads of even[k] and odd[k]. Go to RD1.
- RD1: capture even[k] into pix_dout_l and odd[k] into pix_dout_odd.
  - If k < N/2-1, issue a read of even[k+1].
  - If k = N/2-1, do not read. pix_dout_r takes even[k] (symmetric extension: x[N] = x[N-2]).
  - Go to OUT.
- OUT: pix_dout_r is loaded from the read data on entry, except at the row end, where it already holds the mirrored value. out_valid is high.
  - On out_ready: if k = N/2-1, go to FIN; otherwise k increments and the FSM returns to RD0.
- FIN: done is pulsed, then IDLE.
- Data outputs are registered and held stable while out_valid && !out_ready.
- start outside IDLE is ignored. It does not raise cfg_err.
- Reset, including mid-line: the FSM returns to IDLE and all indices clear. Bank contents are not cleared; the next line overwrites them.

## Timing
- Reset values: in_ready=0, out_valid=0, done=0, busy=0, cfg_err=0, and pix_dout_l, pix_dout_odd, pix_dout_r are all 0.
- start at cycle t: busy and in_ready are high from t+1.
- Input: one sample per cycle at full rate. in_ready drops the cycle after the last sample is accepted.
- Last input beat at cycle t: the FSM is in RD0 at t+1 and the first out_valid is at t+3.
- Output throughput: one tuple per 3 cycles with out_ready held high. The RD0/RD1/OUT loop must be preserved; no prefetch is permitted.
- The last tuple accepted at cycle t gives done=1 at t+1 and IDLE at t+2. A new start is accepted from t+2.
- out_valid never deasserts without a handshake.

## Structure
- Shared package lift_pkg:
  - state enum
  - DATA_W and ADDR_W defaults
  - the min-length constant (4)
  - a function that checks length legality
- Sub-module lift_bank_ram: a single-port synchronous RAM parametrised on width and depth. Instantiated twice, once for even and once for odd.
- The top holds the FSM, the index counters and the output registers.

## Test plan
- N=8, x=10..17, out_ready=1 → tuples (10,11,12), (12,13,14), (14,15,16), (16,17,16). done pulses once; the first out_valid is 3 cycles after the last input beat.
- N=4 at DATA_W=26 with x={0x3FFFFFF,1,2,3} → (0x3FFFFFF,1,2), (2,3,2). No truncation of the full-width value.
- Backpressure: N=8 with out_ready toggling 1-0-0-1 → outputs stay stable while stalled, no tuple is lost or duplicated, and the tuple order matches the first scenario.
- Illegal lengths: start with N=5, then N=2, then N=130 (ADDR_W=7) → cfg_err pulses each time, busy stays 0, and in_ready stays 0.
- Reset mid-FILL after 3 beats, then N=6 with x=1..6 → tuples (1,2,3), (3,4,5), (5,6,5). No stale data appears.
- start asserted during OUT → ignored: no cfg_err, and the current line completes unchanged.
